// File: rtl/token_sched_pkg.sv
// Shared defaults and the round-robin pointer helper for the token repeat scheduler.
package token_sched_pkg;

   localparam int N_REQ_DEF       = 4;
   localparam int REPEAT_DEF      = 2;
   localparam int MAX_PENDING_DEF = 200;
   localparam int CNT_W_DEF       = 8;

   // Next round-robin search position after idx, wrapping modulo n.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request after last_grant_i.
module rr_arbiter
   import token_sched_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] last_grant_i,
   input  logic             enable_i,
   output logic             grant_valid_o,
   output logic [IDX_W-1:0] grant_idx_o
);

   logic [IDX_W-1:0] scan_idx;

   // Walk the requesters starting one past the last winner; the first hit wins.
   always_comb begin
      // NOTE: every variable written here gets a default first so no latch is inferred.
      grant_valid_o = 1'b0;
      grant_idx_o   = '0;
      scan_idx      = last_grant_i;
      for (int k = 0; k < N_REQ; k++) begin
         scan_idx = IDX_W'(rr_next(int'(scan_idx), N_REQ));
         if (enable_i && !grant_valid_o && req_i[scan_idx]) begin
            grant_valid_o = 1'b1;
            grant_idx_o   = scan_idx;
         end
      end
   end

endmodule

// File: rtl/token_repeat_scheduler.sv
// Shares one serial token output among N_REQ inputs; each accepted token is
// repeated REPEAT times, scheduled round-robin, with sticky per-input overflow.
module token_repeat_scheduler
   import token_sched_pkg::*;
#(
   parameter int N_REQ       = N_REQ_DEF,
   parameter int REPEAT      = REPEAT_DEF,
   parameter int MAX_PENDING = MAX_PENDING_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int IDX_W       = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] a,
   input  logic             out_ready,
   output logic             b,
   output logic [IDX_W-1:0] b_src,
   output logic [N_REQ-1:0] overflow,
   output logic             busy
);

   localparam logic [CNT_W-1:0] REPEAT_C   = CNT_W'(REPEAT);
   localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MAX_PENDING);
   localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
   localparam logic [IDX_W-1:0] LAST_RST_C = IDX_W'(N_REQ - 1);

   logic [CNT_W-1:0] pending_q [N_REQ];
   logic [CNT_W-1:0] pending_d [N_REQ];
   logic [N_REQ-1:0] overflow_q, overflow_d;
   logic [IDX_W-1:0] last_grant_q, last_grant_d;
   logic             b_q, b_d;
   logic [IDX_W-1:0] b_src_q, b_src_d;
   logic [N_REQ-1:0] req;
   logic             grant_valid;
   logic [IDX_W-1:0] grant_idx;

   // Eligibility and busy come from registered counters only, never from this cycle's inputs.
   always_comb begin
      req  = '0;
      busy = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         req[i] = (pending_q[i] != '0) && !overflow_q[i];
         busy   = busy | (pending_q[i] != '0);
      end
   end

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req_i         (req),
      .last_grant_i  (last_grant_q),
      .enable_i      (out_ready),
      .grant_valid_o (grant_valid),
      .grant_idx_o   (grant_idx)
   );

   // Next state: accept input tokens, trip overflow, apply the grant decrement, load outputs.
   always_comb begin
      overflow_d = overflow_q;
      for (int i = 0; i < N_REQ; i++) begin
         pending_d[i] = pending_q[i];
         if (a[i] && !overflow_q[i]) begin
            // Compare against the pre-grant backlog; no wrap since pending <= MAX_PENDING.
            if (pending_q[i] + REPEAT_C > MAX_C) begin
               overflow_d[i] = 1'b1;
               pending_d[i]  = '0;
            end else begin
               pending_d[i]  = pending_q[i] + REPEAT_C;
            end
         end
         // A tripping requester loses its backlog, including this cycle's grant.
         if (grant_valid && (grant_idx == IDX_W'(i)) && !overflow_d[i]) begin
            pending_d[i] = pending_d[i] - ONE_C;
         end
      end
      b_d          = grant_valid;
      b_src_d      = grant_valid ? grant_idx : '0;
      last_grant_d = grant_valid ? grant_idx : last_grant_q;
   end

   // Register update; synchronous reset overrides everything and drops all backlog.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples values from before the edge.
      if (rst) begin
         // NOTE: the pending array is ordinary flops, not a RAM, so reset clears it in one cycle.
         for (int i = 0; i < N_REQ; i++) pending_q[i] <= '0;
         overflow_q   <= '0;
         last_grant_q <= LAST_RST_C;
         b_q          <= 1'b0;
         b_src_q      <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) pending_q[i] <= pending_d[i];
         overflow_q   <= overflow_d;
         last_grant_q <= last_grant_d;
         b_q          <= b_d;
         b_src_q      <= b_src_d;
      end
   end

   assign b        = b_q;
   assign b_src    = b_src_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_token_repeat_scheduler.sv
// Scoreboard bench: stimulus pushes hand-derived b_src sequences, a negedge monitor pops them.
module tb_token_repeat_scheduler;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [N_REQ-1:0] a;
   logic             out_ready;
   logic             b;
   logic [IDX_W-1:0] b_src;
   logic [N_REQ-1:0] overflow;
   logic             busy;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   token_repeat_scheduler #(
      .N_REQ       (N_REQ),
      .REPEAT      (2),
      .MAX_PENDING (200),
      .CNT_W       (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .out_ready (out_ready),
      .b         (b),
      .b_src     (b_src),
      .overflow  (overflow),
      .busy      (busy)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Advance one cycle; inputs change and registered outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      a   = '0;
      step();
      rst = 1'b0;
   endtask

   // Wait (bounded) for every expected token to appear, then require an idle output.
   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      check({name, "_drained"}, exp_q.size(), 0);
      check({name, "_b_idle"}, int'(b), 0);
      check({name, "_busy_idle"}, int'(busy), 0);
      exp_q.delete();
   endtask

   // Monitor: every output token must match the next expected owner.
   always @(negedge clk) begin
      if (b === 1'b1) begin
         if (exp_q.size() == 0) check("sb_unexpected_token", int'(b), 0);
         else check("sb_b_src", int'(b_src), exp_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      a         = '0;
      out_ready = 1'b1;
      step();
      step();
      check("rst_b", int'(b), 0);
      check("rst_b_src", int'(b_src), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_overflow", int'(overflow), 0);
      rst = 1'b0;

      // Single token on a[2] in cycle t: b high in t+2, t+3; busy high t+1..t+2.
      a = 4'b0100;
      exp_q.push_back(2); exp_q.push_back(2);
      step(); a = '0;
      check("single_b_t1", int'(b), 0);
      check("single_busy_t1", int'(busy), 1);
      step();
      check("single_b_t2", int'(b), 1);
      check("single_src_t2", int'(b_src), 2);
      check("single_busy_t2", int'(busy), 1);
      step();
      check("single_b_t3", int'(b), 1);
      check("single_busy_t3", int'(busy), 0);
      step();
      check("single_b_t4", int'(b), 0);
      wait_drain("single", 10);

      // Contention: a[0] and a[1] together -> 0,1,0,1.
      do_reset();
      a = 4'b0011;
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
      step(); a = '0;
      step();
      check("cont_first_src", int'(b_src), 0);
      wait_drain("cont", 10);

      // Backpressure: token on a[3], out_ready low cycles 1-10, released in cycle 11.
      do_reset();
      out_ready = 1'b0;
      a = 4'b1000;
      exp_q.push_back(3); exp_q.push_back(3);
      step(); a = '0;
      for (int i = 1; i <= 10; i++) begin
         check("bp_b_low", int'(b), 0);
         check("bp_busy_held", int'(busy), 1);
         step();
      end
      out_ready = 1'b1;
      check("bp_b_c11", int'(b), 0);
      step();
      check("bp_b_c12", int'(b), 1);
      check("bp_src_c12", int'(b_src), 3);
      wait_drain("bp", 10);

      // Overflow: 100 tokens fill pending[1] to 200, the 101st trips the flag.
      do_reset();
      out_ready = 1'b0;
      a = 4'b0010;
      for (int c = 0; c < 100; c++) step();
      check("ovf_not_yet", int'(overflow), 0);
      check("ovf_busy_full", int'(busy), 1);
      step();
      check("ovf_tripped", int'(overflow), 2);
      check("ovf_busy_dropped", int'(busy), 0);
      a = 4'b0011;
      out_ready = 1'b1;
      exp_q.push_back(0); exp_q.push_back(0);
      step(); a = 4'b0010;
      wait_drain("ovf_a0", 20);
      check("ovf_sticky", int'(overflow), 2);
      a = '0;

      // Mixed load: a[0] for 40 cycles, a[2] every 4th -> 20x(0,2) then 60x0.
      do_reset();
      for (int k = 0; k < 20; k++) begin
         exp_q.push_back(0); exp_q.push_back(2);
      end
      for (int k = 0; k < 60; k++) exp_q.push_back(0);
      for (int c = 0; c < 40; c++) begin
         a = (c % 4 == 0) ? 4'b0101 : 4'b0001;
         step();
      end
      a = '0;
      wait_drain("mixed", 200);
      check("mixed_no_overflow", int'(overflow), 0);

      // a[0] alone for 150 cycles: backlog peaks near 151, never overflows.
      do_reset();
      for (int k = 0; k < 300; k++) exp_q.push_back(0);
      a = 4'b0001;
      for (int c = 0; c < 150; c++) step();
      a = '0;
      check("solo_no_overflow_mid", int'(overflow), 0);
      wait_drain("solo", 400);
      check("solo_no_overflow_end", int'(overflow), 0);

      // Reset mid-operation: pending[0]=37, overflow[2]=1, then reset.
      do_reset();
      out_ready = 1'b0;
      for (int c = 0; c <= 100; c++) begin
         a = (c < 19) ? 4'b0101 : 4'b0100;
         step();
      end
      a = '0;
      check("rmid_ovf2", int'(overflow), 4);
      out_ready = 1'b1;
      exp_q.push_back(0);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rmid_b", int'(b), 0);
      check("rmid_b_src", int'(b_src), 0);
      check("rmid_busy", int'(busy), 0);
      check("rmid_overflow", int'(overflow), 0);
      check("rmid_sb_empty", exp_q.size(), 0);
      a = 4'b0110;
      exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(2);
      step(); a = '0;
      step();
      check("rmid_first_src", int'(b_src), 1);
      wait_drain("rmid", 10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
